// File: rtl/noise_multichannel_filler.sv
// Writes num_ch square pseudo-random noise maps back-to-back into a BRAM region.
// Each word packs LANES samples, one per independent 32-bit Galois LFSR.
module noise_multichannel_filler #(
    parameter int DATA_WIDTH   = 64,
    parameter int SAMPLE_WIDTH = 16,
    parameter int LANES        = 4,
    parameter int ADDR_WIDTH   = 14,
    parameter int CH_WIDTH     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            size,
    input  logic [CH_WIDTH-1:0]   num_ch,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [31:0]           seed,
    input  logic                  mode,
    input  logic                  abort,
    input  logic                  bram_ready,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_wdata,
    output logic                  bram_we,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int SW         = SAMPLE_WIDTH;
    localparam int LANE_SHIFT = (LANES == 4) ? 2 : (LANES == 2) ? 1 : 0;
    localparam int T_W        = CH_WIDTH + 17;
    localparam logic [T_W-1:0] MAX_T = T_W'(1) << ADDR_WIDTH;
    localparam logic [31:0]    TAPS  = 32'h80200003;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FILL, S_DONE} state_t;
    state_t r_state, w_state_next;

    logic [2:0]            r_size;
    logic [CH_WIDTH-1:0]   r_num_ch;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [31:0]           r_seed;
    logic                  r_mode;
    logic [T_W-1:0]        r_total;
    logic [T_W-1:0]        r_idx;
    logic                  r_err;

    logic [4:0]            w_shamt;
    logic [16:0]           w_side_sq;
    logic [16:0]           w_wpc;
    logic [T_W-1:0]        w_total;
    logic                  w_reject;
    logic                  w_xfer;
    logic                  w_last;
    logic [DATA_WIDTH-1:0] w_wdata;

    // Map area is 2^(2*size+2) samples; full-width product so oversize jobs are caught.
    assign w_shamt   = {1'b0, r_size, 1'b0} + 5'd2;
    assign w_side_sq = 17'd1 << w_shamt;
    assign w_wpc     = w_side_sq >> LANE_SHIFT;
    assign w_total   = T_W'(r_num_ch) * T_W'(w_wpc);
    assign w_reject  = (w_total == '0) || (w_total > MAX_T);
    assign w_xfer    = (r_state == S_FILL) && bram_ready;
    assign w_last    = (r_idx == r_total - T_W'(1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        bram_we      = 1'b0;
        bram_addr    = '0;
        bram_wdata   = '0;
        busy         = 1'b0;
        done         = 1'b0;
        err          = 1'b0;
        case (r_state)
            S_IDLE: if (start) w_state_next = S_LOAD;
            S_LOAD: begin
                busy         = 1'b1;
                w_state_next = w_reject ? S_DONE : S_FILL;
            end
            S_FILL: begin
                busy       = 1'b1;
                bram_we    = 1'b1;
                bram_addr  = r_base + r_idx[ADDR_WIDTH-1:0];
                bram_wdata = w_wdata;
                // Abort wins over completion; the coinciding transfer still happens.
                if (abort)                w_state_next = S_IDLE;
                else if (w_xfer && w_last) w_state_next = S_DONE;
            end
            S_DONE: begin
                done         = 1'b1;
                err          = r_err;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_size   <= '0;
            r_num_ch <= '0;
            r_base   <= '0;
            r_seed   <= '0;
            r_mode   <= 1'b0;
            r_total  <= '0;
            r_idx    <= '0;
            r_err    <= 1'b0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_size   <= size;
                r_num_ch <= num_ch;
                r_base   <= base_addr;
                r_seed   <= seed;
                r_mode   <= mode;
            end
            if (r_state == S_LOAD) begin
                r_total <= w_total;
                r_idx   <= '0;
                r_err   <= w_reject;
            end else if (w_xfer) begin
                r_idx <= r_idx + T_W'(1);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            localparam logic [31:0] LANE_KEY = 32'h9E3779B9 * 32'(gi);
            logic [31:0]          r_lfsr;
            logic [31:0]          w_seeded;
            logic signed [9:0]    w_bsum;
            logic signed [SW-1:0] w_gauss;
            logic [SW-1:0]        w_sample;

            assign w_seeded = r_seed ^ LANE_KEY;

            // Streams run on across channel boundaries; only LOAD reseeds.
            always_ff @(posedge clk) begin
                if (rst)
                    r_lfsr <= '0;
                else if (r_state == S_LOAD)
                    r_lfsr <= (w_seeded == 32'h0) ? 32'h1 : w_seeded;
                else if (w_xfer)
                    r_lfsr <= r_lfsr[0] ? ((r_lfsr >> 1) ^ TAPS) : (r_lfsr >> 1);
            end

            assign w_bsum   = 10'($signed(r_lfsr[7:0]))   + 10'($signed(r_lfsr[15:8]))
                            + 10'($signed(r_lfsr[23:16])) + 10'($signed(r_lfsr[31:24]));
            assign w_gauss  = SW'(w_bsum);
            assign w_sample = r_mode ? w_gauss : r_lfsr[SW-1:0];
            assign w_wdata[gi*SW +: SW] = w_sample;
        end
    endgenerate
endmodule

// File: tb/tb_noise_multichannel_filler.sv
// Scoreboard bench for noise_multichannel_filler: stimulus pushes expected writes,
// a negedge monitor pops and compares every accepted BRAM word.
module tb_noise_multichannel_filler;
    logic        clk = 1'b0;
    logic        rst, start, mode, abort, bram_ready;
    logic [2:0]  size;
    logic [3:0]  num_ch;
    logic [13:0] base_addr, bram_addr;
    logic [31:0] seed;
    logic [63:0] bram_wdata;
    logic        bram_we, busy, done, err;

    always #5 clk = ~clk;

    noise_multichannel_filler dut (
        .clk(clk), .rst(rst), .start(start), .size(size), .num_ch(num_ch),
        .base_addr(base_addr), .seed(seed), .mode(mode), .abort(abort),
        .bram_ready(bram_ready), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
        .bram_we(bram_we), .busy(busy), .done(done), .err(err)
    );

    typedef struct packed {logic [13:0] a; logic [63:0] d;} exp_t;
    exp_t        exp_q[$];
    int          checks = 0, failures = 0, cyc = 0;
    logic        tb_mode = 1'b0;
    bit          cap_first = 0, have_stall = 0;
    logic [63:0] first_word = '0, st_data = '0;
    logic [13:0] st_addr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
    endfunction

    function automatic logic [15:0] lane_sample(input logic [31:0] s, input logic md);
        int sm;
        if (!md) return s[15:0];
        sm = int'($signed(s[7:0])) + int'($signed(s[15:8]))
           + int'($signed(s[23:16])) + int'($signed(s[31:24]));
        return 16'(sm);
    endfunction

    function automatic logic in_range(input logic [63:0] w);
        logic signed [15:0] v;
        for (int i = 0; i < 4; i++) begin
            v = w[i*16 +: 16];
            if (v < -16'sd512 || v > 16'sd508) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Expected word stream of a job, truncated to at most limit words.
    task automatic push_stream(input int sz, input int nch, input logic [13:0] base,
                               input logic [31:0] sd, input logic md, input int limit);
        logic [31:0] st [4];
        logic [13:0] ad;
        logic [63:0] wd;
        int w, t;
        w = (1 << (2 * sz + 2)) / 4;
        t = nch * w;
        if (t == 0 || t > 16384) t = 0;
        if (t > limit) t = limit;
        for (int i = 0; i < 4; i++) begin
            st[i] = sd ^ (32'h9E3779B9 * 32'(i));
            if (st[i] == 32'h0) st[i] = 32'h1;
        end
        for (int k = 0; k < t; k++) begin
            ad = base + 14'(k);
            wd = {lane_sample(st[3], md), lane_sample(st[2], md),
                  lane_sample(st[1], md), lane_sample(st[0], md)};
            exp_q.push_back('{a: ad, d: wd});
            for (int i = 0; i < 4; i++) st[i] = lfsr_step(st[i]);
        end
    endtask

    // Monitor: every accepted word is popped and compared; stalls must hold addr/data.
    always @(negedge clk) begin
        if (bram_we) begin
            if (have_stall) begin
                check("stall_addr", 64'(bram_addr), 64'(st_addr));
                check("stall_data", bram_wdata, st_data);
            end
            if (bram_ready) begin
                have_stall = 0;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 64'(bram_addr), 64'h3FFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", 64'(bram_addr), 64'(e.a));
                    check("wr_data", bram_wdata, e.d);
                end
                if (cap_first) begin
                    first_word = bram_wdata;
                    cap_first  = 0;
                end
                if (tb_mode) check("gauss_range", 64'(in_range(bram_wdata)), 64'd1);
            end else begin
                have_stall = 1;
                st_addr    = bram_addr;
                st_data    = bram_wdata;
            end
        end else begin
            have_stall = 0;
        end
    end

    task automatic run_job(input int sz, input int nch, input logic [13:0] base,
                           input logic [31:0] sd, input logic md, input bit rnd,
                           input logic exp_err, input int exp_done, input string name);
        int s0, n;
        push_stream(sz, nch, base, sd, md, 1 << 30);
        tb_mode = md;
        @(posedge clk); #1;
        start = 1'b1; size = 3'(sz); num_ch = 4'(nch); base_addr = base; seed = sd; mode = md;
        s0 = cyc;
        @(posedge clk); #1;
        start = 1'b0; size = 3'($urandom); seed = $urandom; base_addr = 14'($urandom); mode = ~md;
        check({name, "_busy_load"}, 64'(busy), 64'd1);
        n = 0;
        while (!done && n < 20000) begin
            bram_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            n++;
        end
        check({name, "_done_seen"}, 64'(done), 64'd1);
        check({name, "_err"}, 64'(err), 64'(exp_err));
        if (exp_done >= 0) check({name, "_done_cycle"}, 64'(cyc - s0), 64'(exp_done));
        check({name, "_words_left"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        bram_ready = 1'b1;
        @(posedge clk); #1;
        check({name, "_idle_after"}, 64'({busy, done, bram_we}), 64'd0);
    endtask

    initial begin
        bit any_done;
        int s0;
        rst = 1'b1; start = 1'b0; size = '0; num_ch = '0; base_addr = '0; seed = '0;
        mode = 1'b0; abort = 1'b0; bram_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", 64'({bram_we, busy, done, err}), 64'd0);
        check("reset_addr", 64'(bram_addr), 64'd0);
        check("reset_wdata", bram_wdata, 64'd0);
        rst = 1'b0;

        cap_first = 1;
        run_job(1, 1, 14'd0, 32'd1, 1'b0, 0, 1'b0, 6, "t1");
        check("t1_first_word", first_word, 64'h6D2AF37379B80001);
        run_job(2, 3, 14'd100, 32'h12345678, 1'b0, 0, 1'b0, 50, "t2");
        run_job(1, 2, 14'd16380, 32'hCAFEF00D, 1'b0, 0, 1'b0, 10, "t3_wrap");
        run_job(7, 2, 14'd0, 32'h11111111, 1'b0, 0, 1'b1, 2, "t4_oversize");
        run_job(1, 0, 14'd7, 32'h22222222, 1'b0, 0, 1'b1, 2, "t4_zero_ch");
        run_job(7, 1, 14'd5, 32'h0BADBEEF, 1'b0, 0, 1'b0, 16386, "t_full_region");
        run_job(2, 3, 14'd40, 32'h5EED5EED, 1'b1, 1, 1'b0, -1, "t5_stall_gauss");
        run_job(1, 1, 14'd9, 32'h0, 1'b1, 0, 1'b0, 6, "t_zero_seed");

        // Abort: ignored in LOAD, honoured on the third FILL cycle.
        push_stream(2, 1, 14'd500, 32'hDEADBEEF, 1'b0, 3);
        tb_mode = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; size = 3'd2; num_ch = 4'd1; base_addr = 14'd500; seed = 32'hDEADBEEF; mode = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_load_ignored", 64'(bram_we), 64'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_we_drop", 64'({bram_we, busy}), 64'd0);
        any_done = done;
        repeat (4) begin
            @(posedge clk); #1;
            any_done |= done;
        end
        check("abort_no_done", 64'(any_done), 64'd0);
        check("abort_words_left", 64'(exp_q.size()), 64'd0);
        exp_q.delete();

        // Reset in the second FILL cycle.
        push_stream(2, 1, 14'd0, 32'd5, 1'b0, 2);
        @(posedge clk); #1;
        start = 1'b1; size = 3'd2; num_ch = 4'd1; base_addr = 14'd0; seed = 32'd5; mode = 1'b0;
        s0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_cycle", 64'(cyc - s0), 64'd4);
        check("rst_ctrl", 64'({bram_we, busy, done, err}), 64'd0);
        check("rst_addr", 64'(bram_addr), 64'd0);
        check("rst_wdata", bram_wdata, 64'd0);
        check("rst_words_left", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        rst = 1'b0;
        run_job(1, 1, 14'd0, 32'd1, 1'b0, 0, 1'b0, 6, "t_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
